// File: rtl/kalman_z_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kalman_pkg
// Brief    : Shared constants, FSM state type and address-width helper for
//            the Kalman Z feeder.
// Revision : 1.0  initial release
// ============================================================================
package kalman_pkg;

    localparam int COL    = 96;
    localparam int DATA_W = 32;
    localparam int Q      = 16;
    localparam int X0_LO  = 200587;
    localparam int X0_HI  = -676877;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } fsm_state_t;

    // Core address carries one extra bit so it can point past the frame.
    function automatic int addr_w(input int col);
        return $clog2(col) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kalman_z_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : kalman_z_feeder_if
// Brief    : Signals exchanged between the feeder and the Kalman iteration
//            core. master = feeder side, slave = core side.
// Revision : 1.0  initial release
// ============================================================================
interface kalman_z_feeder_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 8
);
    logic                kal_start;
    logic [AW-1:0]       kal_cnt_b;
    logic [DATA_W-1:0]   kal_z;
    logic                kal_finsh;
    logic                kal_data_v;
    logic [DATA_W-1:0]   kal_data;
    logic [2*DATA_W-1:0] kal_state;

    modport master (
        output kal_start, kal_z, kal_state,
        input  kal_cnt_b, kal_finsh, kal_data_v, kal_data
    );

    modport slave (
        input  kal_start, kal_z, kal_state,
        output kal_cnt_b, kal_finsh, kal_data_v, kal_data
    );
endinterface
`default_nettype wire

// File: rtl/kalman_z_feeder_bank.sv
`default_nettype none
// ============================================================================
// Module   : kalman_z_bank
// Brief    : Ping-pong Z store, two banks of COL words. One write port and
//            one registered read port; out-of-frame addresses read as zero.
// Revision : 1.0  initial release
// ============================================================================
module kalman_z_bank #(
    parameter int COL    = 96,
    parameter int DATA_W = 32,
    parameter int IW     = 7,
    parameter int AW     = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              wr_en,
    input  wire logic              wr_bank,
    input  wire logic [IW-1:0]     wr_idx,
    input  wire logic [DATA_W-1:0] wr_data,
    input  wire logic              rd_bank,
    input  wire logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0]      rd_data
);
    logic [DATA_W-1:0] r_mem [2][COL];
    logic [DATA_W-1:0] r_rd_data;
    logic              w_in_range;
    logic [IW-1:0]     w_rd_idx;

    assign w_in_range = (rd_addr < AW'(COL));
    assign w_rd_idx   = w_in_range ? rd_addr[IW-1:0] : '0;
    assign rd_data    = r_rd_data;

    // Storage write; contents are not reset, validity lives in the full flags.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_bank][wr_idx] <= wr_data;
        end
    end

    // Registered read, zero for addresses beyond the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_in_range ? r_mem[rd_bank][w_rd_idx] : '0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/kalman_z_feeder.sv
`default_nettype none
// ============================================================================
// Module   : kalman_z_feeder
// Brief    : Host-side responder for the Kalman core. Buffers Z frames in a
//            ping-pong store, starts the core per frame, assembles the core's
//            lo/hi result words into the 64-bit state and streams it out.
// Revision : 1.0  initial release
// ============================================================================
module kalman_z_feeder #(
    parameter int COL       = kalman_pkg::COL,
    parameter int DATA_W    = kalman_pkg::DATA_W,
    parameter int X0_LO     = kalman_pkg::X0_LO,
    parameter int X0_HI     = kalman_pkg::X0_HI,
    parameter int START_DLY = 3
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              z_wr_v,
    input  wire logic [DATA_W-1:0] z_wr_data,
    output logic                   z_ready,
    output logic                   z_ovf,
    kalman_z_feeder_if.master      core,
    output logic                   x_v,
    output logic [2*DATA_W-1:0]    x_data,
    output logic [31:0]            frame_cnt
);
    import kalman_pkg::*;

    localparam int c_IW = $clog2(COL);
    localparam int c_AW = addr_w(COL);
    localparam int c_CW = (START_DLY > 1) ? $clog2(START_DLY) : 1;
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(COL - 1);

    fsm_state_t          r_fsm;
    logic [1:0]          r_full;
    logic [1:0]          w_full_nxt;
    logic                r_wr_bank;
    logic [c_IW-1:0]     r_wr_idx;
    logic                r_rd_bank;
    logic [c_CW-1:0]     r_cnt;
    logic                r_start;
    logic                r_ovf;
    logic                r_word_sel;
    logic [DATA_W-1:0]   r_state_lo;
    logic [DATA_W-1:0]   r_state_hi;
    logic                r_xv;
    logic [2*DATA_W-1:0] r_xdata;
    logic [31:0]         r_frame_cnt;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_wr_ok;
    logic                w_wr_last;
    logic                w_release;
    logic                w_start_entry;

    assign w_wr_ok       = z_wr_v && !r_full[r_wr_bank];
    assign w_wr_last     = w_wr_ok && (r_wr_idx == c_LAST_IDX);
    assign w_release     = (r_fsm == S_DRAIN) && (r_cnt == '0);
    assign w_start_entry = (r_fsm == S_IDLE) && r_full[r_rd_bank];

    assign z_ready        = !r_full[r_wr_bank];
    assign z_ovf          = r_ovf;
    assign core.kal_start = r_start;
    assign core.kal_z     = w_rd_data;
    assign core.kal_state = {r_state_hi, r_state_lo};
    assign x_v            = r_xv;
    assign x_data         = r_xdata;
    assign frame_cnt      = r_frame_cnt;

    kalman_z_bank #(
        .COL    (COL),
        .DATA_W (DATA_W),
        .IW     (c_IW),
        .AW     (c_AW)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_ok),
        .wr_bank (r_wr_bank),
        .wr_idx  (r_wr_idx),
        .wr_data (z_wr_data),
        .rd_bank (r_rd_bank),
        .rd_addr (core.kal_cnt_b),
        .rd_data (w_rd_data)
    );

    // Next full flags: writer completion and reader release may land together.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_release) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    // Writer side: index/bank advance, full flags and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_wr_idx  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_ok) begin
                if (w_wr_last) begin
                    r_wr_idx  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_idx <= r_wr_idx + c_IW'(1);
                end
            end
            if (z_wr_v && !w_wr_ok) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Frame sequencer: start the core, wait for finish, hold off, release bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_start     <= 1'b0;
            r_cnt       <= '0;
            r_rd_bank   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        r_fsm   <= S_START;
                        r_start <= 1'b1;
                    end
                end
                S_START: begin
                    r_fsm <= S_RUN;
                end
                S_RUN: begin
                    if (core.kal_finsh) begin
                        r_fsm <= S_DRAIN;
                        r_cnt <= c_CW'(START_DLY - 1);
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_rd_bank   <= ~r_rd_bank;
                        r_frame_cnt <= r_frame_cnt + 32'd1;
                        r_fsm       <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_CW'(1);
                    end
                end
                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

    // Result assembly: alternate lo/hi words, publish state after each hi word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_sel <= 1'b0;
            r_state_lo <= DATA_W'(X0_LO);
            r_state_hi <= DATA_W'(X0_HI);
            r_xv       <= 1'b0;
            r_xdata    <= '0;
        end else begin
            r_xv <= 1'b0;
            if (core.kal_data_v) begin
                if (!r_word_sel) begin
                    r_state_lo <= core.kal_data;
                end else begin
                    r_state_hi <= core.kal_data;
                    r_xv       <= 1'b1;
                    r_xdata    <= {core.kal_data, r_state_lo};
                end
            end
            if (w_start_entry) begin
                r_word_sel <= 1'b0;
            end else if (core.kal_data_v) begin
                r_word_sel <= ~r_word_sel;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_kalman_z_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_kalman_z_feeder
// Brief    : Self-checking bench for kalman_z_feeder. A bench-side core model
//            consumes frames; expected Z reads and state words go into queues
//            that monitors pop when the DUT presents them.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_kalman_z_feeder;
    localparam int COL = 96;
    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam logic [31:0] X0_LO_V = 32'd200587;
    localparam logic [31:0] X0_HI_V = 32'hFFF5_ABF3;   // -676877

    typedef struct {
        int          cyc;
        logic [31:0] v;
    } rd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          z_wr_v = 1'b0;
    logic [31:0]   z_wr_data = '0;
    logic          z_ready;
    logic          z_ovf;
    logic          x_v;
    logic [63:0]   x_data;
    logic [31:0]   frame_cnt;

    kalman_z_feeder_if #(.DATA_W(DW), .AW(AW)) kif ();

    kalman_z_feeder #(
        .COL(COL), .DATA_W(DW), .X0_LO(200587), .X0_HI(-676877), .START_DLY(3)
    ) dut (
        .clk(clk), .rst(rst), .z_wr_v(z_wr_v), .z_wr_data(z_wr_data),
        .z_ready(z_ready), .z_ovf(z_ovf), .core(kif),
        .x_v(x_v), .x_data(x_data), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int starts_seen = 0;
    int frames_started = 0;
    int xv_count = 0;
    logic prev_start = 1'b0;

    // reference model
    logic [31:0] mw[$];          // accepted Z words in arrival order
    logic [63:0] xq[$];          // expected state outputs
    rd_t         zq[$];          // expected Z read data
    logic [63:0] m_state;
    int          m_buffered = 0; // complete frames not yet released
    int          m_partial  = 0;
    logic        m_ovf      = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitors: start pulse width, state outputs, Z read data.
    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
        end else begin
            if (kif.kal_start) begin
                starts_seen++;
                chk("start_width_prev", {63'd0, prev_start}, 64'd0);
            end
            prev_start = kif.kal_start;
            if (x_v) begin
                xv_count++;
                if (xq.size() == 0) begin
                    chk("x_v_unexpected_qsize", 64'(xq.size()), 64'd1);
                end else begin
                    chk("x_data", x_data, xq.pop_front());
                end
            end
            while (zq.size() > 0 && zq[0].cyc <= cyc) begin
                rd_t e;
                e = zq.pop_front();
                chk("kal_z_cycle", 64'(e.cyc), 64'(cyc));
                chk("kal_z", {32'd0, kif.kal_z}, {32'd0, e.v});
            end
        end
    end

    task automatic write_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            z_wr_v    = 1'b1;
            z_wr_data = 32'(base + i);
            if (m_buffered < 2) begin
                mw.push_back(32'(base + i));
                m_partial++;
                if (m_partial == COL) begin
                    m_partial = 0;
                    m_buffered++;
                end
            end else begin
                m_ovf = 1'b1;
            end
        end
        @(negedge clk);
        z_wr_v = 1'b0;
    endtask

    task automatic wait_start();
        int t;
        t = 0;
        while (starts_seen <= frames_started && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("start_seen", 64'(starts_seen), 64'(frames_started + 1));
        frames_started = starts_seen;
    endtask

    // Bench-side core: read Z, return lo/hi words, finish, watch release timing.
    task automatic core_frame(input int nrd, input logic [31:0] lo, input logic [31:0] hi,
                              input bit dir);
        logic [31:0] fr [COL];
        logic [31:0] fc0;
        int          a;
        int          dir_addr [4];
        dir_addr = '{5, 100, 0, 95};
        wait_start();
        for (int i = 0; i < COL; i++) begin
            fr[i] = (mw.size() > 0) ? mw.pop_front() : 32'hDEAD_BEEF;
        end
        chk("kal_state_at_start", kif.kal_state, m_state);
        for (int r = 0; r < nrd; r++) begin
            @(negedge clk);
            a = (dir && r < 4) ? dir_addr[r] : int'($urandom_range(0, 127));
            kif.kal_cnt_b = AW'(a);
            zq.push_back('{cyc + 1, (a < COL) ? fr[a] : 32'd0});
        end
        @(negedge clk);
        kif.kal_data_v = 1'b1;
        kif.kal_data   = lo;
        @(negedge clk);
        kif.kal_data = hi;
        xq.push_back({hi, lo});
        m_state = {hi, lo};
        @(negedge clk);
        kif.kal_data_v = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        fc0 = frame_cnt;
        kif.kal_finsh = 1'b1;
        @(negedge clk);
        kif.kal_finsh = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("frame_cnt_before_release", {32'd0, frame_cnt}, {32'd0, fc0});
        if (dir) chk("z_ready_before_release", {63'd0, z_ready}, {63'd0, (m_buffered < 2)});
        @(negedge clk);
        if (m_buffered > 0) m_buffered--;
        chk("frame_cnt_after_release", {32'd0, frame_cnt}, {32'd0, fc0 + 32'd1});
        if (dir) chk("z_ready_after_release", {63'd0, z_ready}, {63'd0, (m_buffered < 2)});
    endtask

    task automatic paced_writer(input int nwords);
        int t;
        for (int i = 0; i < nwords; i++) begin
            @(negedge clk);
            t = 0;
            while ((!z_ready || $urandom_range(0, 7) == 0) && t < 2000) begin
                z_wr_v = 1'b0;
                @(negedge clk);
                t++;
            end
            z_wr_v    = 1'b1;
            z_wr_data = $urandom;
            mw.push_back(z_wr_data);
        end
        @(negedge clk);
        z_wr_v = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        kif.kal_cnt_b  = '0;
        kif.kal_finsh  = 1'b0;
        kif.kal_data_v = 1'b0;
        kif.kal_data   = '0;
        m_state = {X0_HI_V, X0_LO_V};

        // Reset values, checked while reset is held
        repeat (3) @(negedge clk);
        chk("rst_z_ready", {63'd0, z_ready}, 64'd1);
        chk("rst_z_ovf", {63'd0, z_ovf}, 64'd0);
        chk("rst_kal_start", {63'd0, kif.kal_start}, 64'd0);
        chk("rst_kal_z", {32'd0, kif.kal_z}, 64'd0);
        chk("rst_kal_state", kif.kal_state, {X0_HI_V, X0_LO_V});
        chk("rst_x_v", {63'd0, x_v}, 64'd0);
        chk("rst_x_data", x_data, 64'd0);
        chk("rst_frame_cnt", {32'd0, frame_cnt}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_no_start", {63'd0, kif.kal_start}, 64'd0);
        end
        chk("idle_z_ready", {63'd0, z_ready}, 64'd1);

        // First frame: words 0..95, start latency, directed reads and results
        write_n(COL, 0);
        chk("start_latency_early", {63'd0, kif.kal_start}, 64'd0);
        @(negedge clk);
        chk("start_latency", {63'd0, kif.kal_start}, 64'd1);
        core_frame(6, 32'h0001_0000, 32'hFFFF_0000, 1'b1);
        chk("state_after_frame1", kif.kal_state, 64'hFFFF_0000_0001_0000);

        // Fill both banks, overflow, then serve both frames in order
        write_n(2 * COL, 1000);
        chk("both_full_z_ready", {63'd0, z_ready}, {63'd0, (m_buffered < 2)});
        write_n(1, 5000);
        chk("ovf_set", {63'd0, z_ovf}, {63'd0, m_ovf});
        chk("ovf_z_ready", {63'd0, z_ready}, 64'd0);
        core_frame(5, $urandom, $urandom, 1'b1);
        core_frame(5, $urandom, $urandom, 1'b1);
        chk("ovf_sticky", {63'd0, z_ovf}, 64'd1);

        // Reset in the middle of a frame
        write_n(COL, 7000);
        wait_start();
        @(negedge clk);
        kif.kal_data_v = 1'b1;
        kif.kal_data   = $urandom;
        @(negedge clk);
        kif.kal_data_v = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        mw.delete();
        m_buffered = 0;
        m_partial  = 0;
        m_ovf      = 1'b0;
        m_state    = {X0_HI_V, X0_LO_V};
        chk("mid_rst_z_ready", {63'd0, z_ready}, 64'd1);
        chk("mid_rst_z_ovf", {63'd0, z_ovf}, 64'd0);
        chk("mid_rst_kal_start", {63'd0, kif.kal_start}, 64'd0);
        chk("mid_rst_kal_z", {32'd0, kif.kal_z}, 64'd0);
        chk("mid_rst_kal_state", kif.kal_state, m_state);
        chk("mid_rst_x_v", {63'd0, x_v}, 64'd0);
        chk("mid_rst_frame_cnt", {32'd0, frame_cnt}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        kif.kal_finsh = 1'b1;
        @(negedge clk);
        kif.kal_finsh = 1'b0;
        repeat (8) @(negedge clk);
        chk("late_finish_frame_cnt", {32'd0, frame_cnt}, 64'd0);
        chk("late_finish_no_start", 64'(starts_seen), 64'(frames_started));
        chk("late_finish_z_ready", {63'd0, z_ready}, 64'd1);

        // 140 frames with a paced random writer
        x0 = xv_count;
        fork
            paced_writer(140 * COL);
            begin
                for (int f = 0; f < 140; f++) begin
                    core_frame(3, $urandom, $urandom, 1'b0);
                end
            end
        join
        repeat (5) @(negedge clk);
        chk("frames_140", {32'd0, frame_cnt}, 64'd140);
        chk("xv_pulses_140", 64'(xv_count - x0), 64'd140);
        chk("no_overflow", {63'd0, z_ovf}, 64'd0);
        chk("xq_empty", 64'(xq.size()), 64'd0);
        chk("zq_empty", 64'(zq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
`default_nettype wire
